// File: rtl/fifo_drain_sink.sv
// fifo_drain_sink: stream sink that drains a valid/ready stream under a
// selectable backpressure pattern and checks the data for an incrementing
// sequence. It reports transfer, mismatch and starvation statistics.
//
// Backpressure modes:
//   0 always ready, 1 on/off duty cycle, 2 pseudo-random (LFSR), 3 halted.
// irdy is a flop whose next value is decided one cycle ahead from the mode
// and the internal state.
module fifo_drain_sink #(
  parameter int unsigned  WIDTH       = 8,
  parameter int unsigned  COUNT_WIDTH = 32,
  parameter logic [15:0]  LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [7:0]             on_cycles,
  input  logic [7:0]             off_cycles,
  input  logic [WIDTH-1:0]       idat,
  input  logic                   ivld,
  output logic                   irdy,
  output logic [COUNT_WIDTH-1:0] beats,
  output logic [COUNT_WIDTH-1:0] errors,
  output logic [COUNT_WIDTH-1:0] first_err,
  output logic                   err,
  output logic [COUNT_WIDTH-1:0] max_gap
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  // Duty-cycle FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  // Mode encoding.
  localparam logic [1:0] MODE_READY = 2'd0;
  localparam logic [1:0] MODE_DUTY  = 2'd1;
  localparam logic [1:0] MODE_RAND  = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]       DATA_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]       DATA_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    logic [COUNT_WIDTH-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // One step of a right-shifting Galois LFSR with taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) begin
      r = r ^ 16'hB400;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // Registered state.
  logic                   irdy_q,      irdy_d;
  logic [1:0]             fsm_q,       fsm_d;
  logic [7:0]             ph_cnt_q,    ph_cnt_d;
  logic [7:0]             ph_len_q,    ph_len_d;
  logic [15:0]            lfsr_q,      lfsr_d;
  logic [WIDTH-1:0]       exp_q,       exp_d;
  logic                   started_q,   started_d;
  logic [COUNT_WIDTH-1:0] beats_q,     beats_d;
  logic [COUNT_WIDTH-1:0] errors_q,    errors_d;
  logic [COUNT_WIDTH-1:0] first_err_q, first_err_d;
  logic                   err_q,       err_d;
  logic [COUNT_WIDTH-1:0] run_q,       run_d;
  logic [COUNT_WIDTH-1:0] max_gap_q,   max_gap_d;

  // Combinational helpers.
  logic        xfer_s;
  logic [7:0]  on_len_s;
  logic [15:0] lfsr_next_s;
  logic        ph_last_s;
  logic [COUNT_WIDTH-1:0] run_inc_s;

  assign xfer_s      = ivld & irdy_q;
  assign on_len_s    = (on_cycles == 8'd0) ? 8'd1 : on_cycles;
  assign lfsr_next_s = lfsr_step(lfsr_q);
  assign ph_last_s   = (({1'b0, ph_cnt_q} + 9'd1) >= {1'b0, ph_len_q});
  assign run_inc_s   = sat_inc(run_q);

  // Backpressure decision: next irdy, duty-cycle FSM and LFSR.
  always_comb begin
    irdy_d   = irdy_q;
    fsm_d    = fsm_q;
    ph_cnt_d = ph_cnt_q;
    ph_len_d = ph_len_q;
    lfsr_d   = lfsr_q;
    case (mode)
      MODE_READY: begin
        fsm_d  = ST_IDLE;
        irdy_d = 1'b1;
      end
      MODE_DUTY: begin
        case (fsm_q)
          ST_IDLE: begin
            fsm_d    = ST_ON;
            ph_cnt_d = 8'd0;
            ph_len_d = on_len_s;
            irdy_d   = 1'b1;
          end
          ST_ON: begin
            if (ph_last_s) begin
              if (off_cycles == 8'd0) begin
                // No off phase: start a fresh on phase, ready stays high.
                fsm_d    = ST_ON;
                ph_cnt_d = 8'd0;
                ph_len_d = on_len_s;
                irdy_d   = 1'b1;
              end else begin
                fsm_d    = ST_OFF;
                ph_cnt_d = 8'd0;
                ph_len_d = off_cycles;
                irdy_d   = 1'b0;
              end
            end else begin
              ph_cnt_d = ph_cnt_q + 8'd1;
              irdy_d   = 1'b1;
            end
          end
          ST_OFF: begin
            if (ph_last_s) begin
              fsm_d    = ST_ON;
              ph_cnt_d = 8'd0;
              ph_len_d = on_len_s;
              irdy_d   = 1'b1;
            end else begin
              ph_cnt_d = ph_cnt_q + 8'd1;
              irdy_d   = 1'b0;
            end
          end
          default: begin
            fsm_d    = ST_IDLE;
            ph_cnt_d = 8'd0;
            irdy_d   = 1'b0;
          end
        endcase
      end
      MODE_RAND: begin
        fsm_d  = ST_IDLE;
        lfsr_d = lfsr_next_s;
        irdy_d = lfsr_next_s[0];
      end
      default: begin
        fsm_d  = ST_IDLE;
        irdy_d = 1'b0;
      end
    endcase
  end

  // Sequence checker and transfer/error statistics, updated only on transfers.
  always_comb begin
    exp_d       = exp_q;
    started_d   = started_q;
    beats_d     = beats_q;
    errors_d    = errors_q;
    first_err_d = first_err_q;
    err_d       = err_q;
    if (xfer_s) begin
      beats_d   = sat_inc(beats_q);
      exp_d     = exp_q + DATA_ONE;
      started_d = 1'b1;
      if (idat != exp_q) begin
        errors_d = sat_inc(errors_q);
        err_d    = 1'b1;
        if (errors_q == CNT_ZERO) begin
          first_err_d = beats_q;
        end else begin
          first_err_d = first_err_q;
        end
      end else begin
        errors_d = errors_q;
      end
    end else begin
      beats_d = beats_q;
    end
  end

  // Starvation tracking: ready but no valid, only after the first transfer.
  always_comb begin
    run_d     = run_q;
    max_gap_d = max_gap_q;
    if (started_q && irdy_q && !ivld) begin
      run_d = run_inc_s;
      if (run_inc_s > max_gap_q) begin
        max_gap_d = run_inc_s;
      end else begin
        max_gap_d = max_gap_q;
      end
    end else begin
      run_d = CNT_ZERO;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      irdy_q      <= 1'b0;
      fsm_q       <= ST_IDLE;
      ph_cnt_q    <= 8'd0;
      ph_len_q    <= 8'd0;
      lfsr_q      <= SEED_EFF;
      exp_q       <= DATA_ZERO;
      started_q   <= 1'b0;
      beats_q     <= CNT_ZERO;
      errors_q    <= CNT_ZERO;
      first_err_q <= CNT_ZERO;
      err_q       <= 1'b0;
      run_q       <= CNT_ZERO;
      max_gap_q   <= CNT_ZERO;
    end else begin
      irdy_q      <= irdy_d;
      fsm_q       <= fsm_d;
      ph_cnt_q    <= ph_cnt_d;
      ph_len_q    <= ph_len_d;
      lfsr_q      <= lfsr_d;
      exp_q       <= exp_d;
      started_q   <= started_d;
      beats_q     <= beats_d;
      errors_q    <= errors_d;
      first_err_q <= first_err_d;
      err_q       <= err_d;
      run_q       <= run_d;
      max_gap_q   <= max_gap_d;
    end
  end

  assign irdy      = irdy_q;
  assign beats     = beats_q;
  assign errors    = errors_q;
  assign first_err = first_err_q;
  assign err       = err_q;
  assign max_gap   = max_gap_q;

endmodule

// File: tb/tb_fifo_drain_sink.sv
// Directed self-checking bench for fifo_drain_sink (default parameters).
module tb_fifo_drain_sink;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [7:0]  on_cycles;
  logic [7:0]  off_cycles;
  logic [7:0]  idat;
  logic        ivld;
  logic        irdy;
  logic [31:0] beats;
  logic [31:0] errors;
  logic [31:0] first_err;
  logic        err;
  logic [31:0] max_gap;

  int checks;
  int failures;

  // Reference LFSR state, bench-side transfer count and previous ready.
  logic [15:0] lm;
  int          xf;
  logic        prev;

  fifo_drain_sink dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .on_cycles  (on_cycles),
    .off_cycles (off_cycles),
    .idat       (idat),
    .ivld       (ivld),
    .irdy       (irdy),
    .beats      (beats),
    .errors     (errors),
    .first_err  (first_err),
    .err        (err),
    .max_gap    (max_gap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    ivld = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Run n cycles in mode 2, comparing irdy with the reference LFSR.
  task automatic run_lfsr(input int n);
    for (int i = 0; i < n; i++) begin
      idat = xf[7:0];
      tick();
      if (prev) xf++;
      lm = ref_step(lm);
      check("lfsr_irdy", 32'(irdy), 32'(lm[0]));
      prev = lm[0];
    end
  endtask

  initial begin
    logic [7:0] vb [0:7];
    checks = 0; failures = 0;
    rst = 1'b1; mode = 2'd0; on_cycles = 8'd0; off_cycles = 8'd0;
    idat = 8'd0; ivld = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_irdy", 32'(irdy), 32'd0);
    check("rst_beats", beats, 32'd0);
    check("rst_errors", errors, 32'd0);
    check("rst_first_err", first_err, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_max_gap", max_gap, 32'd0);

    // Mode 0 streaming 0..99
    rst = 1'b0; mode = 2'd0; ivld = 1'b1; idat = 8'd0;
    tick();
    check("m0_irdy_cycle2", 32'(irdy), 32'd1);
    check("m0_beats_start", beats, 32'd0);
    for (int i = 0; i < 100; i++) begin
      idat = 8'(i);
      tick();
    end
    ivld = 1'b0;
    check("m0_beats", beats, 32'd100);
    check("m0_errors", errors, 32'd0);
    check("m0_err", 32'(err), 32'd0);
    check("m0_max_gap", max_gap, 32'd0);

    // Single corrupted beat: 0,1,2,7,4,5 then 6,7
    vb[0] = 8'd0; vb[1] = 8'd1; vb[2] = 8'd2; vb[3] = 8'd7;
    vb[4] = 8'd4; vb[5] = 8'd5; vb[6] = 8'd6; vb[7] = 8'd7;
    do_reset();
    mode = 2'd0;
    tick();
    ivld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idat = vb[i];
      tick();
      if (i == 2) check("err_before", 32'(err), 32'd0);
      if (i == 3) begin
        check("err_errors", errors, 32'd1);
        check("err_first_err", first_err, 32'd3);
        check("err_flag", 32'(err), 32'd1);
      end
      if (i == 5) check("err_beats6", beats, 32'd6);
    end
    ivld = 1'b0;
    check("err_errors_final", errors, 32'd1);
    check("err_first_final", first_err, 32'd3);
    check("err_beats_final", beats, 32'd8);

    // Starvation gaps: none before first beat, then 5, then 2
    do_reset();
    mode = 2'd0;
    tick(); tick(); tick(); tick();
    check("gap_pre_first", max_gap, 32'd0);
    ivld = 1'b1; idat = 8'd0;
    tick();
    ivld = 1'b0;
    tick(); tick(); tick();
    check("gap_running3", max_gap, 32'd3);
    tick(); tick();
    check("gap_running5", max_gap, 32'd5);
    ivld = 1'b1; idat = 8'd1;
    tick();
    ivld = 1'b0;
    tick(); tick();
    check("gap_max", max_gap, 32'd5);
    check("gap_beats", beats, 32'd2);
    check("gap_errors", errors, 32'd0);

    // Duty cycle on=3 off=2, ivld held high
    do_reset();
    mode = 2'd1; on_cycles = 8'd3; off_cycles = 8'd2; ivld = 1'b1;
    xf = 0; idat = 8'd0;
    tick();
    for (int k = 0; k < 100; k++) begin
      check("duty_irdy", 32'(irdy), ((k % 5) < 3) ? 32'd1 : 32'd0);
      idat = xf[7:0];
      tick();
      if ((k % 5) < 3) xf++;
    end
    check("duty_beats", beats, 32'd60);
    check("duty_errors", errors, 32'd0);

    // Halt: irdy drops the next cycle, beats frozen
    mode = 2'd3; ivld = 1'b0;
    tick();
    check("halt_irdy", 32'(irdy), 32'd0);
    ivld = 1'b1; idat = xf[7:0];
    tick(); tick(); tick();
    check("halt_irdy_hold", 32'(irdy), 32'd0);
    check("halt_beats", beats, 32'd60);

    // Duty cycle with on=0 off=0: ready constantly high
    mode = 2'd1; on_cycles = 8'd0; off_cycles = 8'd0;
    tick();
    for (int k = 0; k < 10; k++) begin
      check("duty0_irdy", 32'(irdy), 32'd1);
      idat = xf[7:0];
      tick();
      xf++;
    end
    check("duty0_beats", beats, 32'd70);
    check("duty0_errors", errors, 32'd0);

    // Pseudo-random backpressure, 1000 cycles
    do_reset();
    mode = 2'd2; ivld = 1'b1;
    lm = 16'hACE1; xf = 0; prev = 1'b0;
    run_lfsr(1000);
    check("lfsr_beats", beats, 32'(xf));
    check("lfsr_errors", errors, 32'd0);

    // Reset mid-run discards the in-flight transfer and reseeds
    rst = 1'b1; idat = xf[7:0];
    tick();
    check("mid_rst_irdy", 32'(irdy), 32'd0);
    check("mid_rst_beats", beats, 32'd0);
    check("mid_rst_errors", errors, 32'd0);
    check("mid_rst_first_err", first_err, 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_max_gap", max_gap, 32'd0);
    rst = 1'b0;
    lm = 16'hACE1; xf = 0; prev = 1'b0;
    run_lfsr(20);

    // LFSR holds while in another mode
    mode = 2'd0;
    for (int k = 0; k < 5; k++) begin
      idat = xf[7:0];
      tick();
      if (prev) xf++;
      check("hold_m0_irdy", 32'(irdy), 32'd1);
      prev = 1'b1;
    end
    mode = 2'd2;
    run_lfsr(20);
    check("reseed_beats", beats, 32'(xf));
    check("reseed_errors", errors, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_drain_sink.md
FIFO_DRAIN_SINK -- requirements
Module: fifo_drain_sink

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of consumed stream.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, width of all statistics counters.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, reset value of the 16-bit backpressure LFSR; a zero value SHALL be replaced by 16'h0001.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mode  input  2  0=always ready, 1=duty cycle, 2=pseudo-random, 3=halted.
REQ-007 SHALL have port on_cycles  input  8  ready-high phase length in duty mode.
REQ-008 SHALL have port off_cycles  input  8  ready-low phase length in duty mode.
REQ-009 SHALL have port idat  input  WIDTH  stream data.
REQ-010 SHALL have port ivld  input  1  stream valid.
REQ-011 SHALL have port irdy  output  1  stream ready, driven directly from a register.
REQ-012 SHALL have port beats  output  COUNT_WIDTH  accepted transfers.
REQ-013 SHALL have port errors  output  COUNT_WIDTH  data-mismatch count.
REQ-014 SHALL have port first_err  output  COUNT_WIDTH  beat index of first mismatch.
REQ-015 SHALL have port err  output  1  sticky mismatch flag.
REQ-016 SHALL have port max_gap  output  COUNT_WIDTH  longest starvation run in cycles.

Function
REQ-017 A transfer SHALL occur in a cycle with ivld=1 and irdy=1; no other cycle changes beats, errors or checker state.
REQ-018 irdy for cycle n+1 SHALL be computed from mode and state in cycle n (one-cycle registered decision).
REQ-019 Mode 0 SHALL set irdy=1 every cycle; mode 3 SHALL set irdy=0 every cycle.
REQ-020 Mode 1 SHALL use FSM states IDLE, ON, OFF; entering mode 1 from any other mode or IDLE SHALL go to ON with phase counter cleared.
REQ-021 In ON, irdy=1 for max(on_cycles,1) cycles then -> OFF; in OFF, irdy=0 for off_cycles cycles then -> ON; off_cycles=0 SHALL skip OFF entirely (irdy held 1).
REQ-022 Phase counters SHALL count cycles, independent of ivld; on_cycles/off_cycles SHALL be sampled at each phase entry.
REQ-023 Mode 2 SHALL advance a Galois LFSR (taps 16,14,13,11) every cycle in mode 2 and set next irdy = LFSR bit 0; the LFSR SHALL hold its value in other modes.
REQ-024 A mode change SHALL take effect on irdy in the cycle after it is sampled; leaving mode 1 SHALL return FSM to IDLE.
REQ-025 Checker SHALL expect idat = 0 on the first transfer after reset, incrementing by 1 modulo 2^WIDTH per transfer.
REQ-026 On mismatch: errors +1, err<=1; if errors was 0, first_err <= beats value before increment (0-based index).
REQ-027 Expected value SHALL advance on every transfer regardless of mismatch (no resynchronisation).
REQ-028 beats, errors and max_gap SHALL saturate at all-ones, never wrap.
REQ-029 Starvation run SHALL count consecutive cycles with irdy=1, ivld=0, only after the first transfer; any transfer or irdy=0 cycle ends the run.
REQ-030 max_gap SHALL update to the running length in the same cycle the running length exceeds it.
REQ-031 All statistics outputs SHALL be registered, reflecting transfers up to the previous clock edge.

Reset
REQ-032 While rst=1: irdy=0, beats=0, errors=0, first_err=0, err=0, max_gap=0, FSM=IDLE, LFSR=LFSR_SEED, expected=0, run counter=0.
REQ-033 Reset asserted mid-operation SHALL take effect at the next edge, discarding any transfer in that cycle; first irdy after release SHALL follow REQ-018.
REQ-034 No output SHALL be X after one reset cycle.

Verification
REQ-035 Mode 0, ivld=1, idat 0..99 -> irdy=1 from cycle 2 after reset, beats=100, errors=0, err=0, max_gap=0.
REQ-036 Mode 1, on=3, off=2, ivld held 1 -> irdy pattern 1,1,1,0,0 repeating; beats=60 after 100 cycles of pattern.
REQ-037 Mode 1, on=0, off=0 -> irdy constant 1; mode 3 -> irdy=0 next cycle, beats frozen.
REQ-038 Mode 0, data 0,1,2,7,4,5 -> errors=1, first_err=3, err=1; after 6 beats no further errors.
REQ-039 Mode 0, beat, then ivld=0 for 5 cycles, beat, ivld=0 for 2 cycles -> max_gap=5.
REQ-040 Mode 2 with default seed, 1000 cycles -> irdy matches reference LFSR model bit-exact; rst mid-run -> all stats 0, LFSR reseeded.
